keypad_event_queue: RTL and testbench
=====================================

// Module: keypad_event_queue
// PURPOSE
//  Downstream consumer of the 4x4 keypad column scanner. Issues periodic scan requests and captures each
//  16-bit active-low scan result. Debounces the decoded key and queues one 4-bit key code per debounced press.
//  The queue is a FIFO that application logic drains with a valid/ready handshake.
// PARAMETERS
//  SCAN_PERIOD     100000  clock cycles from return-to-idle until the next o_Read pulse (>=2)
//  DATA_TIMEOUT    8192    max cycles to wait for scanner data after o_Read (must exceed the scanner's 4x1025-cycle scan)
//  DEBOUNCE_SCANS  3       consecutive identical decoded scans needed to accept a change (1..15)
//  FIFO_DEPTH      8       key-code queue depth; power of two, >=2
// PORTS
//  i_Clock           in   1      system clock; all logic on rising edge
//  i_Rst_L           in   1      asynchronous, active-low reset
//  o_Read            out  1      one-cycle scan request to scanner
//  i_Keypad_State    in   16     scanner result: bit low = contact closed
//  i_Keypad_DV       in   1      scanner data-valid (level; rises when result is ready)
//  o_Key             out  4      key code at FIFO head (first-word fall-through)
//  o_Key_Valid       out  1      FIFO non-empty
//  i_Key_Ready       in   1      consumer accepts o_Key when o_Key_Valid && i_Key_Ready
//  o_Key_Held        out  1      debounced state: a key is currently pressed
//  o_Fifo_Count      out  $clog2(FIFO_DEPTH)+1  entries queued
//  o_Overflow        out  1      sticky; a press was dropped because FIFO full
//  i_Clear_Overflow  in   1      synchronous clear of o_Overflow
// BEHAVIOUR
//  Reset: all outputs 0. FIFO empty, debounce history cleared (candidate = no key, count 0), timer 0, FSM WAIT_TIMER.
//   Reset mid-scan abandons the scan. Queued codes are lost.
//  FSM states and transitions:
//   WAIT_TIMER: count to SCAN_PERIOD-1, then go to REQUEST.
//   REQUEST: o_Read=1 for exactly this cycle, then go to WAIT_DATA.
//   WAIT_DATA: sample on a rising edge of i_Keypad_DV (registered dv_q; dv_q updates in all states).
//    On the edge, register i_Keypad_State and go to EVALUATE.
//    If DATA_TIMEOUT cycles elapse with no edge, go to WAIT_TIMER; the scan is discarded and debounce is untouched.
//   EVALUATE: one cycle of debounce and push; then clear the timer and go to WAIT_TIMER.
//  DV is ignored outside WAIT_DATA, so a DV high level at reset exit or a stale DV is never a sample.
//  Decode: keypad_decode(state) -> {pressed, code[3:0]}; priority goes to the highest-index low bit.
//   Map, bit15..bit0: 1,4,7,0,2,5,8,F,3,6,9,E,A,B,C,D. All bits high -> pressed=0, code=0.
//  Debounce (in EVALUATE); cand = decoded {pressed, code}:
//   cand == last_cand: cnt = min(cnt+1, DEBOUNCE_SCANS).
//   otherwise: last_cand = cand, cnt = 1.
//   When cnt reaches DEBOUNCE_SCANS on this scan and cand != deb, deb takes cand.
//   If the new deb has pressed=1, push deb.code.
//   So a press-to-release or key-to-key change pushes only a new pressed key. Holding pushes once (no auto-repeat).
//  o_Key_Held = deb.pressed; it updates in the cycle after EVALUATE.
//  FIFO:
//   pop  = o_Key_Valid && i_Key_Ready.
//   push = debounce event.
//   o_Key/o_Key_Valid reflect the head registered; a push into an empty FIFO is visible the next cycle.
//   Full with push && pop in the same cycle: both occur, count unchanged.
//   Full with push and no pop: code dropped, o_Overflow<=1.
//   Empty with pop: ignored (cannot happen, since valid=0).
//   Pointers wrap modulo FIFO_DEPTH; the count is tracked separately, so full and empty are unambiguous.
//   Same-cycle i_Clear_Overflow and a new overflow: set wins.
// STRUCTURE
//  keypad_pkg holds:
//   KEY_W=4 and the KEY_0..KEY_F code constants.
//   The 16-entry bit-to-code map and function keypad_decode.
//   The FSM state encoding (WAIT_TIMER, REQUEST, WAIT_DATA, EVALUATE).
//  Sub-module keypad_key_fifo: generic sync FIFO, parameterised on width and depth, with count output.
//   It is instantiated once for key codes and also holds the overflow flag logic.
//  Debounce, FSM and timers are in this module.
// TESTING (bench params: SCAN_PERIOD=16, DATA_TIMEOUT=64, DEBOUNCE_SCANS=3, FIFO_DEPTH=4; behavioural scanner model)
//  1 Reset release, no keys (0xFFFF):
//    first o_Read is 1 cycle wide at cycle 16 after reset release; periodic thereafter.
//    o_Key_Valid, o_Key_Held and o_Overflow stay 0.
//  2 Model returns 0xF7FF (bit11 low, key 2) for 3 scans:
//    exactly one push, o_Key=4'h2, o_Key_Valid=1, o_Key_Held=1.
//    10 more identical scans add no entries.
//  3 Bounce, scan sequence 0xFFFE,0xFFFF,0xFFFE,0xFFFE,0xFFFE:
//    push 4'hD only after the 5th scan. No push on the isolated first scan.
//  4 Simultaneous bits: 0x7FFE (bits15 and 0 low) -> code 4'h1 after debounce. Priority is the highest index.
//  5 i_Key_Ready=0, five distinct debounced presses (1,2,3,4,5):
//    o_Fifo_Count=4 and o_Overflow=1.
//    Drain order is 1,2,3,4. Then pulse i_Clear_Overflow -> o_Overflow=0.
//    Also: full with push+pop same cycle -> count stays 4, no overflow.
//  6 Model withholds DV:
//    return to WAIT_TIMER 64 cycles after o_Read; next o_Read follows 16 cycles later.
//    Assert i_Rst_L low in WAIT_DATA with 2 codes queued -> all outputs 0 immediately, FIFO empty.

Source files
------------

// File: rtl/keypad_pkg.sv
//==============================================================================
// keypad_pkg -- key codes, bit-to-code map, decode function, FSM encoding.
// Rev 1.0
//==============================================================================
`default_nettype none

package keypad_pkg;

    localparam int KEY_W = 4;

    localparam logic [KEY_W-1:0] KEY_0 = 4'h0;
    localparam logic [KEY_W-1:0] KEY_1 = 4'h1;
    localparam logic [KEY_W-1:0] KEY_2 = 4'h2;
    localparam logic [KEY_W-1:0] KEY_3 = 4'h3;
    localparam logic [KEY_W-1:0] KEY_4 = 4'h4;
    localparam logic [KEY_W-1:0] KEY_5 = 4'h5;
    localparam logic [KEY_W-1:0] KEY_6 = 4'h6;
    localparam logic [KEY_W-1:0] KEY_7 = 4'h7;
    localparam logic [KEY_W-1:0] KEY_8 = 4'h8;
    localparam logic [KEY_W-1:0] KEY_9 = 4'h9;
    localparam logic [KEY_W-1:0] KEY_A = 4'hA;
    localparam logic [KEY_W-1:0] KEY_B = 4'hB;
    localparam logic [KEY_W-1:0] KEY_C = 4'hC;
    localparam logic [KEY_W-1:0] KEY_D = 4'hD;
    localparam logic [KEY_W-1:0] KEY_E = 4'hE;
    localparam logic [KEY_W-1:0] KEY_F = 4'hF;

    localparam logic [1:0] ST_WAIT_TIMER = 2'd0;
    localparam logic [1:0] ST_REQUEST    = 2'd1;
    localparam logic [1:0] ST_WAIT_DATA  = 2'd2;
    localparam logic [1:0] ST_EVALUATE   = 2'd3;

    typedef struct packed {
        logic             pressed;
        logic [KEY_W-1:0] code;
    } key_evt_t;

    function automatic logic [KEY_W-1:0] bit_to_code(input logic [3:0] idx);
        logic [KEY_W-1:0] code;
        case (idx)
            4'd15:   code = KEY_1;
            4'd14:   code = KEY_4;
            4'd13:   code = KEY_7;
            4'd12:   code = KEY_0;
            4'd11:   code = KEY_2;
            4'd10:   code = KEY_5;
            4'd9:    code = KEY_8;
            4'd8:    code = KEY_F;
            4'd7:    code = KEY_3;
            4'd6:    code = KEY_6;
            4'd5:    code = KEY_9;
            4'd4:    code = KEY_E;
            4'd3:    code = KEY_A;
            4'd2:    code = KEY_B;
            4'd1:    code = KEY_C;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

    // Ascending scan so the highest-index closed contact is the one that sticks.
    function automatic key_evt_t keypad_decode(input logic [15:0] state);
        key_evt_t evt;
        evt = '0;
        for (int i = 0; i < 16; i++) begin
            if (!state[i]) begin
                evt.pressed = 1'b1;
                evt.code    = bit_to_code(4'(i));
            end
        end
        return evt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_key_fifo.sv
//==============================================================================
// keypad_key_fifo -- first-word fall-through sync FIFO with count and sticky overflow.
// Rev 1.0
//==============================================================================
`default_nettype none

module keypad_key_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       clear_overflow,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];
    assign valid   = (count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push && !do_push) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/keypad_event_queue.sv
//==============================================================================
// keypad_event_queue -- periodic scan requests, debounce, and queue of pressed key codes.
// Rev 1.0
//==============================================================================
`default_nettype none

module keypad_event_queue
    import keypad_pkg::*;
#(
    parameter int SCAN_PERIOD    = 100000,
    parameter int DATA_TIMEOUT   = 8192,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          i_Clock,
    input  logic                          i_Rst_L,
    output logic                          o_Read,
    input  logic [15:0]                   i_Keypad_State,
    input  logic                          i_Keypad_DV,
    output logic [KEY_W-1:0]              o_Key,
    output logic                          o_Key_Valid,
    input  logic                          i_Key_Ready,
    output logic                          o_Key_Held,
    output logic [$clog2(FIFO_DEPTH):0]   o_Fifo_Count,
    output logic                          o_Overflow,
    input  logic                          i_Clear_Overflow
);

    localparam int TIMER_MAX = (SCAN_PERIOD > DATA_TIMEOUT) ? SCAN_PERIOD : DATA_TIMEOUT;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

    logic [1:0]         state;
    logic [TIMER_W-1:0] timer;
    logic               dv_q;
    logic [15:0]        scan_data;
    key_evt_t           last_cand;
    key_evt_t           deb;
    logic [3:0]         deb_cnt;

    key_evt_t           cand;
    logic [3:0]         cnt_next;
    logic               accept;
    logic               push;
    logic               dv_rise;

    assign cand    = keypad_decode(scan_data);
    assign dv_rise = i_Keypad_DV && !dv_q;

    always_comb begin
        cnt_next = 4'd1;
        if (cand == last_cand) begin
            cnt_next = (deb_cnt >= 4'(DEBOUNCE_SCANS)) ? 4'(DEBOUNCE_SCANS) : deb_cnt + 4'd1;
        end
    end

    assign accept     = (state == ST_EVALUATE) && (cnt_next == 4'(DEBOUNCE_SCANS)) && (cand != deb);
    assign push       = accept && cand.pressed;
    assign o_Read     = (state == ST_REQUEST);
    assign o_Key_Held = deb.pressed;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state     <= ST_WAIT_TIMER;
            timer     <= '0;
            dv_q      <= 1'b0;
            scan_data <= 16'hFFFF;
            last_cand <= '0;
            deb       <= '0;
            deb_cnt   <= 4'd0;
        end else begin
            dv_q <= i_Keypad_DV;
            case (state)
                ST_WAIT_TIMER: begin
                    if (timer == TIMER_W'(SCAN_PERIOD - 1)) begin
                        timer <= '0;
                        state <= ST_REQUEST;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_REQUEST: begin
                    // The request cycle counts toward the data timeout.
                    timer <= TIMER_W'(1);
                    state <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: begin
                    if (dv_rise) begin
                        scan_data <= i_Keypad_State;
                        state     <= ST_EVALUATE;
                    end else if (timer == TIMER_W'(DATA_TIMEOUT - 1)) begin
                        timer <= '0;
                        state <= ST_WAIT_TIMER;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                default: begin
                    last_cand <= cand;
                    deb_cnt   <= cnt_next;
                    if (accept) begin
                        deb <= cand;
                    end
                    timer <= '0;
                    state <= ST_WAIT_TIMER;
                end
            endcase
        end
    end

    keypad_key_fifo #(
        .WIDTH (KEY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk            (i_Clock),
        .rst_n          (i_Rst_L),
        .push           (push),
        .push_data      (cand.code),
        .pop            (i_Key_Ready),
        .clear_overflow (i_Clear_Overflow),
        .rd_data        (o_Key),
        .valid          (o_Key_Valid),
        .count          (o_Fifo_Count),
        .overflow       (o_Overflow)
    );

endmodule

`default_nettype wire

// File: tb/tb_keypad_event_queue.sv
//==============================================================================
// tb_keypad_event_queue -- scanner model plus queue/debounce reference for keypad_event_queue.
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_keypad_event_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd;
    logic [15:0] kstate;
    logic        dv;
    logic [3:0]  key;
    logic        kvalid;
    logic        ready;
    logic        held;
    logic [2:0]  cnt;
    logic        ovf;
    logic        clr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rel   = 0;

    // Reference model: bit index -> key code, queue of codes, debounce run tracking.
    logic [3:0] kmap [16] = '{4'hD, 4'hC, 4'hB, 4'hA, 4'hE, 4'h9, 4'h6, 4'h3,
                              4'hF, 4'h8, 4'h5, 4'h2, 4'h0, 4'h7, 4'h4, 4'h1};
    int         q [$];
    logic [4:0] m_last;
    logic [4:0] m_deb;
    int         m_run;
    bit         m_ovf;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    keypad_event_queue #(
        .SCAN_PERIOD    (16),
        .DATA_TIMEOUT   (64),
        .DEBOUNCE_SCANS (3),
        .FIFO_DEPTH     (4)
    ) dut (
        .i_Clock          (clk),
        .i_Rst_L          (rst_n),
        .o_Read           (rd),
        .i_Keypad_State   (kstate),
        .i_Keypad_DV      (dv),
        .o_Key            (key),
        .o_Key_Valid      (kvalid),
        .i_Key_Ready      (ready),
        .o_Key_Held       (held),
        .o_Fifo_Count     (cnt),
        .o_Overflow       (ovf),
        .i_Clear_Overflow (clr)
    );

    function automatic logic [4:0] ref_decode(input logic [15:0] st);
        for (int i = 15; i >= 0; i--) begin
            if (!st[i]) return {1'b1, kmap[i]};
        end
        return 5'd0;
    endfunction

    task automatic model_reset();
        q.delete();
        m_last = 5'd0;
        m_deb  = 5'd0;
        m_run  = 0;
        m_ovf  = 1'b0;
    endtask

    task automatic model_scan(input logic [15:0] st, input bit popped);
        logic [4:0] c;
        c = ref_decode(st);
        if (c == m_last) m_run++;
        else begin
            m_last = c;
            m_run  = 1;
        end
        if (popped && q.size() > 0) void'(q.pop_front());
        if (m_run == 3 && c != m_deb) begin
            m_deb = c;
            if (c[4]) begin
                if (q.size() < 4) q.push_back(int'(c[3:0]));
                else m_ovf = 1'b1;
            end
        end
    endtask

    // One scan transaction: answer the next o_Read, then compare outputs with the model.
    task automatic do_scan(input logic [15:0] st, input int d, input bit give_dv,
                           input bit pop_eval, output int rcyc);
        int guard;
        guard = 0;
        while (rd !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        rcyc = cyc;
        total++;
        if (rd !== 1'b1) begin
            bad++;
            $display("FAIL read_wait: o_Read=%b required 1 within 300 cycles", rd);
            return;
        end
        dv = 1'b0;
        @(negedge clk);
        total++;
        if (rd !== 1'b0) begin
            bad++;
            $display("FAIL read_width: o_Read=%b required 0 one cycle after request", rd);
        end
        if (!give_dv) return;
        repeat (d - 1) @(negedge clk);
        kstate = st;
        dv     = 1'b1;
        @(negedge clk);
        if (pop_eval) begin
            if (q.size() > 0) begin
                total++;
                if (key !== q[0][3:0]) begin
                    bad++;
                    $display("FAIL eval_pop_key: o_Key=%h required %h", key, q[0][3:0]);
                end
            end
            ready = 1'b1;
        end
        @(negedge clk);
        ready = 1'b0;
        model_scan(st, pop_eval);
        total++;
        if (cnt !== 3'(q.size())) begin
            bad++;
            $display("FAIL scan_count st=%h: o_Fifo_Count=%0d required %0d", st, cnt, q.size());
        end
        total++;
        if (kvalid !== (q.size() > 0)) begin
            bad++;
            $display("FAIL scan_valid st=%h: o_Key_Valid=%b required %b", st, kvalid, q.size() > 0);
        end
        if (q.size() > 0) begin
            total++;
            if (key !== q[0][3:0]) begin
                bad++;
                $display("FAIL scan_key st=%h: o_Key=%h required %h", st, key, q[0][3:0]);
            end
        end
        total++;
        if (held !== m_deb[4]) begin
            bad++;
            $display("FAIL scan_held st=%h: o_Key_Held=%b required %b", st, held, m_deb[4]);
        end
        total++;
        if (ovf !== m_ovf) begin
            bad++;
            $display("FAIL scan_overflow st=%h: o_Overflow=%b required %b", st, ovf, m_ovf);
        end
    endtask

    task automatic pop_one();
        if (q.size() > 0) begin
            total++;
            if (key !== q[0][3:0]) begin
                bad++;
                $display("FAIL pop_key: o_Key=%h required %h", key, q[0][3:0]);
            end
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        if (q.size() > 0) void'(q.pop_front());
        total++;
        if (cnt !== 3'(q.size())) begin
            bad++;
            $display("FAIL pop_count: o_Fifo_Count=%0d required %0d", cnt, q.size());
        end
    endtask

    task automatic press(input logic [15:0] st, input bit pop_last);
        int rc;
        do_scan(st, $urandom_range(1, 5), 1'b1, 1'b0, rc);
        do_scan(st, $urandom_range(1, 5), 1'b1, 1'b0, rc);
        do_scan(st, $urandom_range(1, 5), 1'b1, pop_last, rc);
        for (int i = 0; i < 3; i++) do_scan(16'hFFFF, $urandom_range(1, 5), 1'b1, 1'b0, rc);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        dv     = 1'b1;
        kstate = 16'hFFFF;
        ready  = 1'b0;
        clr    = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({rd, kvalid, held, ovf, cnt, key} !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs: rd=%b valid=%b held=%b ovf=%b cnt=%0d key=%h required all 0",
                     rd, kvalid, held, ovf, cnt, key);
        end
        model_reset();
        rst_n = 1'b1;
        rel   = cyc;
    endtask

    task automatic test_idle();
        int r0, r1, r2;
        do_scan(16'hFFFF, 3, 1'b1, 1'b0, r0);
        total++;
        if (r0 - rel != 16) begin
            bad++;
            $display("FAIL first_read: at cycle %0d required 16", r0 - rel);
        end
        do_scan(16'hFFFF, 5, 1'b1, 1'b0, r1);
        total++;
        if (r1 - r0 != 3 + 18) begin
            bad++;
            $display("FAIL read_period_a: gap %0d required %0d", r1 - r0, 3 + 18);
        end
        do_scan(16'hFFFF, 1, 1'b1, 1'b0, r2);
        total++;
        if (r2 - r1 != 5 + 18) begin
            bad++;
            $display("FAIL read_period_b: gap %0d required %0d", r2 - r1, 5 + 18);
        end
    endtask

    task automatic test_press();
        int rc;
        for (int i = 0; i < 13; i++) do_scan(16'hF7FF, $urandom_range(1, 5), 1'b1, 1'b0, rc);
        total++;
        if (cnt !== 3'd1 || key !== 4'h2 || held !== 1'b1) begin
            bad++;
            $display("FAIL press_hold: cnt=%0d key=%h held=%b required 1 2 1", cnt, key, held);
        end
        pop_one();
        for (int i = 0; i < 3; i++) do_scan(16'hFFFF, $urandom_range(1, 5), 1'b1, 1'b0, rc);
    endtask

    task automatic test_bounce();
        int rc;
        do_scan(16'hFFFE, 2, 1'b1, 1'b0, rc);
        total++;
        if (cnt !== 3'd0) begin
            bad++;
            $display("FAIL bounce_isolated: o_Fifo_Count=%0d required 0", cnt);
        end
        do_scan(16'hFFFF, 2, 1'b1, 1'b0, rc);
        for (int i = 0; i < 3; i++) do_scan(16'hFFFE, $urandom_range(1, 5), 1'b1, 1'b0, rc);
        total++;
        if (cnt !== 3'd1 || key !== 4'hD) begin
            bad++;
            $display("FAIL bounce_push: cnt=%0d key=%h required 1 D", cnt, key);
        end
        pop_one();
        for (int i = 0; i < 3; i++) do_scan(16'hFFFF, $urandom_range(1, 5), 1'b1, 1'b0, rc);
    endtask

    task automatic test_priority();
        int rc;
        for (int i = 0; i < 3; i++) do_scan(16'h7FFE, $urandom_range(1, 5), 1'b1, 1'b0, rc);
        total++;
        if (cnt !== 3'd1 || key !== 4'h1) begin
            bad++;
            $display("FAIL priority: cnt=%0d key=%h required 1 1", cnt, key);
        end
        pop_one();
        for (int i = 0; i < 3; i++) do_scan(16'hFFFF, $urandom_range(1, 5), 1'b1, 1'b0, rc);
    endtask

    task automatic test_overflow();
        press(16'h7FFF, 1'b0);
        press(16'hF7FF, 1'b0);
        press(16'hFF7F, 1'b0);
        press(16'hBFFF, 1'b0);
        press(16'hFBFF, 1'b0);
        total++;
        if (cnt !== 3'd4 || ovf !== 1'b1) begin
            bad++;
            $display("FAIL overflow_full: cnt=%0d ovf=%b required 4 1", cnt, ovf);
        end
        for (int i = 0; i < 4; i++) pop_one();
        total++;
        if (ovf !== 1'b1) begin
            bad++;
            $display("FAIL overflow_sticky: o_Overflow=%b required 1", ovf);
        end
        clr = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
        m_ovf = 1'b0;
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL overflow_clear: o_Overflow=%b required 0", ovf);
        end
        press(16'hFFBF, 1'b0);
        press(16'hDFFF, 1'b0);
        press(16'hFDFF, 1'b0);
        press(16'hFFDF, 1'b0);
        press(16'hFFEF, 1'b1);
        total++;
        if (cnt !== 3'd4 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL full_push_pop: cnt=%0d ovf=%b required 4 0", cnt, ovf);
        end
        for (int i = 0; i < 4; i++) pop_one();
    endtask

    task automatic test_random();
        logic [15:0] pat;
        int          rc;
        pat = 16'hFFFF;
        for (int n = 0; n < 40; n++) begin
            int r;
            r = $urandom_range(0, 5);
            if (r == 0) pat = 16'hFFFF;
            else if (r == 1) begin
                pat = 16'hFFFF;
                pat[$urandom_range(0, 15)] = 1'b0;
                if ($urandom_range(0, 1) == 1) pat[$urandom_range(0, 15)] = 1'b0;
            end
            do_scan(pat, $urandom_range(1, 6), 1'b1, ($urandom_range(0, 7) == 0), rc);
            if ($urandom_range(0, 3) == 0) pop_one();
        end
    endtask

    task automatic test_timeout_reset();
        int rc, rt, rn, guard;
        for (int i = 0; i < 3; i++) do_scan(16'hFFFF, $urandom_range(1, 5), 1'b1, 1'b0, rc);
        while (q.size() > 0) pop_one();
        clr = 1'b1;
        @(negedge clk);
        clr   = 1'b0;
        m_ovf = 1'b0;
        do_scan(16'hFFFB, 2, 1'b1, 1'b0, rc);
        do_scan(16'hFFFB, 3, 1'b1, 1'b0, rc);
        do_scan(16'hFFFB, 1, 1'b0, 1'b0, rt);
        do_scan(16'hFFFB, 2, 1'b1, 1'b0, rn);
        total++;
        if (rn - rt != 80) begin
            bad++;
            $display("FAIL timeout_gap: gap %0d required 80", rn - rt);
        end
        total++;
        if (cnt !== 3'd1 || key !== 4'hB) begin
            bad++;
            $display("FAIL timeout_keeps_debounce: cnt=%0d key=%h required 1 B", cnt, key);
        end
        for (int i = 0; i < 3; i++) do_scan(16'hFFFD, $urandom_range(1, 5), 1'b1, 1'b0, rc);
        guard = 0;
        while (rd !== 1'b1 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        dv = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({rd, kvalid, held, ovf, cnt, key} !== 11'd0) begin
            bad++;
            $display("FAIL midscan_reset: rd=%b valid=%b held=%b ovf=%b cnt=%0d key=%h required all 0",
                     rd, kvalid, held, ovf, cnt, key);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
        do_scan(16'hFFFF, 2, 1'b1, 1'b0, rc);
        total++;
        if (rc - rel != 16) begin
            bad++;
            $display("FAIL read_after_reset: at cycle %0d required 16", rc - rel);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_idle();
        test_press();
        test_bounce();
        test_priority();
        test_overflow();
        test_random();
        test_timeout_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
